// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Miss/writeback sequencer for the L1 data-cache SRAM array.
//                Serves hits with no added latency. On a miss it writes back
//                a dirty victim, fetches the block, fills the array, then
//                replays the request. Saturating hit/miss/writeback counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int BLK_ADDR_W = 26,
    parameter int BLK_BYTES  = 32,
    parameter int BLK_BITS   = 256,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU MEM stage
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [BLK_ADDR_W-1:0] cpu_addr,
    input  logic [BLK_BYTES-1:0]  cpu_bytes,
    input  logic [BLK_BITS-1:0]   cpu_wdata,
    output logic [BLK_BITS-1:0]   cpu_rdata,
    output logic                  cpu_stall,
    // data-cache array
    output logic                  sram_ren,
    output logic                  sram_wen,
    output logic                  sram_memWen,
    output logic [BLK_BYTES-1:0]  sram_bytes,
    output logic [BLK_ADDR_W-1:0] sram_blockAddr,
    output logic [BLK_BITS-1:0]   sram_dataIn,
    input  logic                  sram_hit,
    input  logic                  sram_dirty,
    input  logic [BLK_BITS-1:0]   sram_dataOut,
    input  logic [BLK_ADDR_W-1:0] sram_victimAddr,
    // next-level memory
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic [BLK_BITS-1:0]   mem_wdata,
    input  logic                  mem_ack,
    input  logic [BLK_BITS-1:0]   mem_rdata,
    // performance counters
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt,
    output logic [CNT_W-1:0]      wb_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WB      = 2'd1,
        S_FILL    = 2'd2,
        S_FILL_WR = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [BLK_ADDR_W-1:0]   mem_addr_q;
    logic [BLK_BITS-1:0]     mem_wdata_q;   // doubles as the victim data buffer
    logic [BLK_BITS-1:0]     fill_q;
    logic [CNT_W-1:0]        hit_cnt_q;
    logic [CNT_W-1:0]        miss_cnt_q;
    logic [CNT_W-1:0]        wb_cnt_q;

    logic w_idle;
    logic w_req;

    assign w_idle = (state_q == S_IDLE);
    assign w_req  = cpu_ren | cpu_wen;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Array strobes are decoded from state; only IDLE passes CPU accesses through.
    assign sram_ren       = w_idle & cpu_ren & ~cpu_wen;
    assign sram_wen       = w_idle & cpu_wen;
    assign sram_memWen    = (state_q == S_FILL_WR);
    assign sram_bytes     = w_idle ? cpu_bytes : '0;
    assign sram_blockAddr = cpu_addr;
    assign sram_dataIn    = (state_q == S_FILL_WR) ? fill_q : cpu_wdata;

    // The CPU proceeds only on an idle cycle that either has no request or hits.
    assign cpu_rdata = sram_dataOut;
    assign cpu_stall = ~(w_idle & (~w_req | sram_hit));

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign wb_cnt    = wb_cnt_q;

    // Miss sequencer: registered memory interface, buffers and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_q      <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        if (sram_hit) begin
                            hit_cnt_q <= sat_inc(hit_cnt_q);
                        end else begin
                            miss_cnt_q <= sat_inc(miss_cnt_q);
                            mem_req_q  <= 1'b1;
                            if (sram_dirty) begin
                                // Victim must reach memory before its slot is refilled.
                                state_q     <= S_WB;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= sram_victimAddr;
                                mem_wdata_q <= sram_dataOut;
                            end else begin
                                state_q    <= S_FILL;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= cpu_addr;
                            end
                        end
                    end
                end
                S_WB: begin
                    // Request stays up and turns straight into the block read.
                    if (mem_ack) begin
                        wb_cnt_q   <= sat_inc(wb_cnt_q);
                        state_q    <= S_FILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= cpu_addr;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        fill_q    <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_FILL_WR;
                    end
                end
                S_FILL_WR: begin
                    // Fill written this cycle; the replay in IDLE then hits.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Scoreboard bench for dcache_ctrl with a 4-set direct-mapped
//                array model and a fixed-latency memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int AW  = 26;
    localparam int NB  = 32;
    localparam int DW  = 256;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main DUT signals
    logic          cpu_ren, cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [NB-1:0] cpu_bytes;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          sram_ren, sram_wen, sram_memWen;
    logic [NB-1:0] sram_bytes;
    logic [AW-1:0] sram_blockAddr;
    logic [DW-1:0] sram_dataIn;
    logic          sram_hit, sram_dirty;
    logic [DW-1:0] sram_dataOut;
    logic [AW-1:0] sram_victimAddr;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          ack_auto, ack_man;
    wire           mem_ack = ack_auto | ack_man;
    logic [DW-1:0] mem_rdata;
    logic [31:0]   hit_cnt, miss_cnt, wb_cnt;

    dcache_ctrl #(.BLK_ADDR_W(AW), .BLK_BYTES(NB), .BLK_BITS(DW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_bytes(cpu_bytes),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
        .sram_bytes(sram_bytes), .sram_blockAddr(sram_blockAddr), .sram_dataIn(sram_dataIn),
        .sram_hit(sram_hit), .sram_dirty(sram_dirty), .sram_dataOut(sram_dataOut),
        .sram_victimAddr(sram_victimAddr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    // narrow-counter DUT: array always hits
    logic          ren2;
    logic          wen2     = 1'b0;
    logic [AW-1:0] addr2    = '0;
    logic [NB-1:0] bytes2   = '0;
    logic [DW-1:0] wdata2   = '0;
    logic          hit2     = 1'b1;
    logic          dirty2   = 1'b0;
    logic [DW-1:0] dout2    = '0;
    logic [AW-1:0] vaddr2   = '0;
    logic          ack2     = 1'b0;
    logic [DW-1:0] rdata2   = '0;
    logic [DW-1:0] cpu_rdata2, sram_dataIn2, mem_wdata2;
    logic          cpu_stall2, sram_ren2, sram_wen2, sram_memWen2, mem_req2, mem_we2;
    logic [NB-1:0] sram_bytes2;
    logic [AW-1:0] sram_blockAddr2, mem_addr2;
    logic [3:0]    hit_cnt2, miss_cnt2, wb_cnt2;

    dcache_ctrl #(.BLK_ADDR_W(AW), .BLK_BYTES(NB), .BLK_BITS(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .cpu_ren(ren2), .cpu_wen(wen2), .cpu_addr(addr2), .cpu_bytes(bytes2),
        .cpu_wdata(wdata2), .cpu_rdata(cpu_rdata2), .cpu_stall(cpu_stall2),
        .sram_ren(sram_ren2), .sram_wen(sram_wen2), .sram_memWen(sram_memWen2),
        .sram_bytes(sram_bytes2), .sram_blockAddr(sram_blockAddr2), .sram_dataIn(sram_dataIn2),
        .sram_hit(hit2), .sram_dirty(dirty2), .sram_dataOut(dout2),
        .sram_victimAddr(vaddr2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ack(ack2), .mem_rdata(rdata2),
        .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2), .wb_cnt(wb_cnt2)
    );

    // ---------------- array model: 4 sets, index = addr[1:0] ----------------
    logic          arr_clr;
    logic          t_val   [4];
    logic          t_dirty [4];
    logic [AW-1:0] t_addr  [4];
    logic [DW-1:0] t_data  [4];

    always_comb begin
        sram_hit        = t_val[sram_blockAddr[1:0]] && (t_addr[sram_blockAddr[1:0]] == sram_blockAddr);
        sram_dirty      = t_dirty[sram_blockAddr[1:0]];
        sram_dataOut    = t_data[sram_blockAddr[1:0]];
        sram_victimAddr = t_addr[sram_blockAddr[1:0]];
    end

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int i = 0; i < 4; i++) begin
                t_val[i] <= 1'b0; t_dirty[i] <= 1'b0; t_addr[i] <= '0; t_data[i] <= '0;
            end
        end else begin
            if (sram_wen && sram_hit) begin
                for (int b = 0; b < NB; b++)
                    if (sram_bytes[b]) t_data[sram_blockAddr[1:0]][b*8 +: 8] <= sram_dataIn[b*8 +: 8];
                t_dirty[sram_blockAddr[1:0]] <= 1'b1;
            end
            if (sram_memWen) begin
                t_val[sram_blockAddr[1:0]]   <= 1'b1;
                t_dirty[sram_blockAddr[1:0]] <= 1'b0;
                t_addr[sram_blockAddr[1:0]]  <= sram_blockAddr;
                t_data[sram_blockAddr[1:0]]  <= sram_dataIn;
            end
        end
    end

    // ---------------- memory model ----------------
    logic [DW-1:0] memstore [logic [AW-1:0]];
    logic          mem_auto;

    function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {8'hD0, a[7:0], 8'h11, a[7:0]};
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] blk_b0(input logic [AW-1:0] a, input logic [7:0] b0);
        logic [DW-1:0] d;
        d = blk(a);
        d[7:0] = b0;
        return d;
    endfunction

    // Ack arrives in the LAT-th cycle of each request; a request held
    // through an ack starts a new transaction in the following cycle.
    initial begin
        int  cnt;
        logic busy;
        ack_auto = 1'b0; mem_rdata = '0; busy = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            ack_auto = 1'b0;
            if (rst || !mem_auto) begin
                busy = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin busy = 1'b1; cnt = 0; end
                cnt++;
                if (cnt == LAT) begin
                    ack_auto = 1'b1;
                    busy     = 1'b0;
                    if (mem_we) memstore[mem_addr] = mem_wdata;
                    else mem_rdata = memstore.exists(mem_addr) ? memstore[mem_addr] : blk(mem_addr);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic is_load; logic [DW-1:0] data; } resp_t;
    typedef struct packed { logic we; logic [AW-1:0] addr; logic [7:0] lane0; } mtx_t;
    typedef struct packed { logic [95:0] nm; logic [DW-1:0] act; logic [DW-1:0] exp; } chk_t;

    resp_t respq[$];
    mtx_t  memq[$];
    chk_t  chkq[$];
    int    total, bad;

    logic req_prev, ack_prev;
    always @(posedge clk) begin
        req_prev <= mem_req;
        ack_prev <= mem_ack;
    end

    function automatic void chk(input logic [95:0] nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        chkq.push_back({nm, a, e});
    endfunction

    task automatic cmp(input logic [95:0] nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %0s: got %h want %h", nm, a, e);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a request or
    // starts a memory transaction, and evaluates queued direct checks.
    initial begin
        resp_t r;
        mtx_t  m;
        chk_t  c;
        total = 0; bad = 0;
        forever begin
            @(negedge clk);
            if (!rst && (cpu_ren || cpu_wen) && !cpu_stall) begin
                if (respq.size() == 0) cmp("resp_extra", 1, 0);
                else begin
                    r = respq.pop_front();
                    if (r.is_load) cmp("load_data", cpu_rdata, r.data);
                end
            end
            if (!rst && mem_req && (!req_prev || ack_prev)) begin
                if (memq.size() == 0) cmp("memtx_extra", 1, 0);
                else begin
                    m = memq.pop_front();
                    cmp("memtx_we", DW'(mem_we), DW'(m.we));
                    cmp("memtx_addr", DW'(mem_addr), DW'(m.addr));
                    if (m.we) cmp("wb_lane0", DW'(mem_wdata[7:0]), DW'(m.lane0));
                end
            end
            while (chkq.size() > 0) begin
                c = chkq.pop_front();
                cmp(c.nm, c.act, c.exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [NB-1:0] be,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp, output int ns);
        logic done;
        respq.push_back({~we, exp});
        @(posedge clk); #1;
        cpu_wen = we; cpu_ren = ~we; cpu_addr = a; cpu_bytes = be; cpu_wdata = wd;
        ns = 0; done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin done = 1'b1; break; end
            ns++;
        end
        if (!done) chk("stall_tmo", 1, 0);
        @(posedge clk); #1;
        cpu_ren = 1'b0; cpu_wen = 1'b0;
    endtask

    task automatic do_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int ns;
        logic seen;
        rst = 1'b1; arr_clr = 1'b1; mem_auto = 1'b1; ack_man = 1'b0; ren2 = 1'b0;
        cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_bytes = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; arr_clr = 1'b0;

        // reset state
        chk("rst_hit", DW'(hit_cnt), 0);
        chk("rst_miss", DW'(miss_cnt), 0);
        chk("rst_wb", DW'(wb_cnt), 0);
        chk("rst_req", DW'(mem_req), 0);
        chk("rst_we", DW'(mem_we), 0);
        chk("rst_addr", DW'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", DW'(cpu_stall), 0);
        chk("rst_strobes", DW'({sram_ren, sram_wen, sram_memWen}), 0);

        // T1: fill 0x10, then hit
        memq.push_back({1'b0, 26'h10, 8'h00});
        do_req(1'b0, 26'h10, '0, '0, blk(26'h10), ns);
        chk("t1_miss_st", DW'(ns), 5);
        chk("t1_miss_cnt", DW'(miss_cnt), 1);
        chk("t1_hit_rep", DW'(hit_cnt), 1);
        do_req(1'b0, 26'h10, '0, '0, blk(26'h10), ns);
        chk("t1_hit_st", DW'(ns), 0);
        chk("t1_hit_cnt", DW'(hit_cnt), 2);

        // T2: clean miss 0x20 (evicts clean 0x10)
        do_rst();
        memq.push_back({1'b0, 26'h20, 8'h00});
        do_req(1'b0, 26'h20, '0, '0, blk(26'h20), ns);
        chk("t2_stall", DW'(ns), 5);
        chk("t2_miss", DW'(miss_cnt), 1);
        chk("t2_wb", DW'(wb_cnt), 0);

        // T3: dirty victim writeback
        do_rst();
        memq.push_back({1'b0, 26'h31, 8'h00});
        do_req(1'b0, 26'h31, '0, '0, blk(26'h31), ns);
        do_req(1'b1, 26'h31, 32'h1, {248'h0, 8'hAA}, '0, ns);
        chk("t3_st_hit", DW'(ns), 0);
        memq.push_back({1'b1, 26'h31, 8'hAA});
        memq.push_back({1'b0, 26'h41, 8'h00});
        do_req(1'b0, 26'h41, '0, '0, blk(26'h41), ns);
        chk("t3_stall", DW'(ns), 8);
        chk("t3_wb", DW'(wb_cnt), 1);
        chk("t3_miss", DW'(miss_cnt), 2);
        memq.push_back({1'b0, 26'h31, 8'h00});
        do_req(1'b0, 26'h31, '0, '0, blk_b0(26'h31, 8'hAA), ns);
        chk("t3_wb_keep", DW'(wb_cnt), 1);

        // T4: store miss allocates then replays the store
        memq.push_back({1'b0, 26'h52, 8'h00});
        do_req(1'b1, 26'h52, 32'h1, {248'h0, 8'h55}, '0, ns);
        chk("t4_stall", DW'(ns), 5);
        do_req(1'b0, 26'h52, '0, '0, blk_b0(26'h52, 8'h55), ns);
        chk("t4_ld_st", DW'(ns), 0);

        // T5: reset mid-fill, late ack ignored
        do_rst();
        mem_auto = 1'b0;
        memq.push_back({1'b0, 26'h63, 8'h00});
        @(posedge clk); #1 cpu_ren = 1'b1; cpu_addr = 26'h63;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin seen = 1'b1; break; end
        end
        chk("t5_req_up", DW'(seen), 1);
        @(posedge clk); #1 rst = 1'b1; cpu_ren = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        chk("t5_req", DW'(mem_req), 0);
        chk("t5_stall", DW'(cpu_stall), 0);
        chk("t5_cnts", DW'({hit_cnt, miss_cnt, wb_cnt}), 0);
        ack_man = 1'b1;
        @(posedge clk); #1 ack_man = 1'b0;
        @(posedge clk); #1;
        chk("t5_late_req", DW'(mem_req), 0);
        chk("t5_late_mw", DW'(sram_memWen), 0);
        chk("t5_late_cnt", DW'({hit_cnt, miss_cnt, wb_cnt}), 0);
        mem_auto = 1'b1;
        memq.push_back({1'b0, 26'h63, 8'h00});
        do_req(1'b0, 26'h63, '0, '0, blk(26'h63), ns);
        chk("t5_retry_st", DW'(ns), 5);
        chk("t5_retry_ms", DW'(miss_cnt), 1);

        // T6: 4-bit counter saturation
        @(posedge clk); #1 ren2 = 1'b1;
        repeat (14) @(posedge clk);
        #1 chk("t6_hit14", DW'(hit_cnt2), 14);
        repeat (6) @(posedge clk);
        #1 ren2 = 1'b0;
        chk("t6_hit_sat", DW'(hit_cnt2), 15);
        repeat (3) @(posedge clk);
        #1 chk("t6_hit_hold", DW'(hit_cnt2), 15);

        // drain
        for (int i = 0; i < 50 && (respq.size() > 0 || memq.size() > 0); i++) @(posedge clk);
        chk("resp_left", DW'(respq.size()), 0);
        chk("memtx_left", DW'(memq.size()), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
